mem1r1w_arbiter: RTL and testbench
==================================

Name: mem1r1w_arbiter

Overview:
- Shares one Mem1R1WHelper instance (one sync read port, one masked write port) between NUM_REQ requesters.
- Independent round-robin arbitration on the read port and the write port.
- Out-of-range index check on every request.
- Read responses are routed back to the issuing requester.
- Sits between the core-side requesters (difftest/ref-model helpers) and the memory helper wrapper.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- RAM_SIZE, 1024, memory depth in 64-bit words. Any index >= RAM_SIZE is out of range.
- IDX_W, 64, index width, matches the helper.
- DATA_W, 64, data/mask width, matches the helper.

Ports:
- clock  in  1  sole clock, all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- rd_req_valid  in  NUM_REQ  per-requester read request.
- rd_req_index  in  NUM_REQ*IDX_W  read indices, requester i at slice i.
- rd_req_ready  out  NUM_REQ  one-hot read grant.
- rd_resp_valid  out  NUM_REQ  one-hot read response strobe.
- rd_resp_data  out  DATA_W  shared response data.
- rd_resp_err  out  1  response carries out-of-range error.
- wr_req_valid  in  NUM_REQ  per-requester write request.
- wr_req_index  in  NUM_REQ*IDX_W  write indices.
- wr_req_data  in  NUM_REQ*DATA_W  write data.
- wr_req_mask  in  NUM_REQ*DATA_W  bit-level write mask.
- wr_req_ready  out  NUM_REQ  one-hot write grant.
- wr_err  out  1  pulses when a granted write was out of range and dropped.
- mem_r_enable / mem_r_index  out  1 / IDX_W  to helper read port.
- mem_r_data  in  DATA_W  from helper, valid 1 cycle after mem_r_enable.
- mem_w_enable / mem_w_index / mem_w_data / mem_w_mask  out  1 / IDX_W / DATA_W / DATA_W  to helper write port.

Behaviour:
- Reset (reset==0 at clock edge):
  - All ready, resp_valid, err and mem enable outputs are 0.
  - Both RR pointers = 0.
  - Read pipe stage empty.
  - rd_resp_data = 0.
- Handshake: a transfer occurs when valid[i] && ready[i].
  - Ready is combinational from valid and the pointer.
  - At most one ready bit per port per cycle.
  - Requesters hold valid and payload until granted.
- Arbitration (each port independent):
  - Grant the first valid requester at or after the port's ptr, wrapping modulo NUM_REQ.
  - After a grant to i, ptr <= (i+1) mod NUM_REQ. Pointer is unchanged when there is no grant.
- Read issue, cycle T:
  - On grant, with index < RAM_SIZE: mem_r_enable=1, mem_r_index=index.
  - Out of range: mem_r_enable=0.
  - In both cases the stage registers {owner, err} for T+1.
- Read response, cycle T+1:
  - rd_resp_valid[owner]=1.
  - rd_resp_data = mem_r_data, or 0 when err.
  - rd_resp_err = err.
  - Fixed latency of 1; no response backpressure. A new read may issue every cycle.
- Write, cycle T:
  - On grant with index in range: mem_w_* driven combinationally that cycle, wr_err=0.
  - Out of range: mem_w_enable=0, wr_err=1 for that cycle (combinational).
- Simultaneous read and write to the same index in one cycle: the read returns pre-write data (helper semantics), unless the optional feature is enabled.
- Range check compares the full IDX_W index against RAM_SIZE; no truncation.
- Reset mid-operation: an in-flight read response is discarded (no rd_resp_valid the cycle after reset).

Optional Feature:
- Macro: MEM1R1W_ARB_WR_FWD_EN.
- Defined:
  - The read stage also registers a hit flag plus the write data and mask when the same-cycle write index equals the read index (both in range).
  - At T+1, rd_resp_data = (mem_r_data & ~mask) | (wdata & mask).
- Undefined: no forwarding logic; the read returns old data.

Decomposition:
- Package mem1r1w_arb_pkg holds:
  - IDX_W and DATA_W constants;
  - owner-index typedef (logic [$clog2(NUM_REQ)-1:0]);
  - read-stage struct {valid, owner, err, fwd_hit, fwd_data, fwd_mask}.
- One sub-module, rr_arbiter (NUM_REQ param; valid in, one-hot grant out, internal pointer), instantiated twice: read and write.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all valids=1 -> all readies, resp_valid, mem enables = 0. First cycle after release grants requester 0 on both ports.
- Round-robin: rd_req_valid=2'b11 held for 4 cycles -> grants 0,1,0,1. rd_resp_valid follows each grant one cycle later with the matching owner.
- Write then read:
  - Req1 writes index 5, data 0xDEAD_BEEF, mask all ones.
  - Next cycle req0 reads index 5 -> rd_resp_valid=2'b01 and rd_resp_data=0xDEAD_BEEF one cycle later.
- Out of range:
  - Read index 1024 -> mem_r_enable=0; next cycle resp_valid to that owner, rd_resp_err=1, data 0.
  - Write index 2000 -> wr_err=1, mem_w_enable=0.
- Same-cycle collision:
  - Index 7 holds 0x1111. Write 0xFFFF with mask 0x00FF while reading index 7.
  - Response is 0x1111 without MEM1R1W_ARB_WR_FWD_EN, 0x11FF with it.
- Reset mid-flight: grant a read at T, assert reset at T+1 -> no rd_resp_valid at T+1 or later.

Source files
------------

// File: rtl/mem1r1w_arb_pkg.sv
// Shared types for the 1R1W memory arbiter: helper widths, owner index and
// the registered read-stage record.
package mem1r1w_arb_pkg;

   localparam int IDX_W   = 64;
   localparam int DATA_W  = 64;
   localparam int MAX_REQ = 8;
   localparam int OWN_W   = $clog2(MAX_REQ);

   // Wide enough for any legal NUM_REQ (2..8).
   typedef logic [OWN_W-1:0] owner_t;

   typedef struct packed {
      logic              valid;
      owner_t            owner;
      logic              err;
      logic              fwd_hit;
      logic [DATA_W-1:0] fwd_data;
      logic [DATA_W-1:0] fwd_mask;
   } rd_stage_t;

   function automatic logic [DATA_W-1:0] merge_fwd(input logic [DATA_W-1:0] old_d,
                                                   input logic [DATA_W-1:0] new_d,
                                                   input logic [DATA_W-1:0] mask);
      return (old_d & ~mask) | (new_d & mask);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after
// the pointer; pointer moves past the winner only when something is granted.
module rr_arbiter
   import mem1r1w_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] valid_i,
   output logic [NUM_REQ-1:0] grant_o
);

   owner_t ptr_q, ptr_d;
   logic   found;

   always_comb begin
      grant_o = '0;
      ptr_d   = ptr_q;
      found   = 1'b0;
      // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rst_ni && !found && valid_i[i] && (i >= int'(ptr_q))) begin
            found      = 1'b1;
            grant_o[i] = 1'b1;
            ptr_d      = (i == NUM_REQ-1) ? '0 : owner_t'(i + 1);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rst_ni && !found && valid_i[i] && (i < int'(ptr_q))) begin
            found      = 1'b1;
            grant_o[i] = 1'b1;
            ptr_d      = (i == NUM_REQ-1) ? '0 : owner_t'(i + 1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mem1r1w_arbiter.sv
// Shares one Mem1R1WHelper (sync read, masked write) among NUM_REQ requesters.
// Define MEM1R1W_ARB_WR_FWD_EN to forward same-cycle write data into a read.
module mem1r1w_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int RAM_SIZE = 1024,
   parameter int IDX_W    = 64,
   parameter int DATA_W   = 64
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        rd_req_valid,
   input  logic [NUM_REQ*IDX_W-1:0]  rd_req_index,
   output logic [NUM_REQ-1:0]        rd_req_ready,
   output logic [NUM_REQ-1:0]        rd_resp_valid,
   output logic [DATA_W-1:0]         rd_resp_data,
   output logic                      rd_resp_err,
   input  logic [NUM_REQ-1:0]        wr_req_valid,
   input  logic [NUM_REQ*IDX_W-1:0]  wr_req_index,
   input  logic [NUM_REQ*DATA_W-1:0] wr_req_data,
   input  logic [NUM_REQ*DATA_W-1:0] wr_req_mask,
   output logic [NUM_REQ-1:0]        wr_req_ready,
   output logic                      wr_err,
   output logic                      mem_r_enable,
   output logic [IDX_W-1:0]          mem_r_index,
   input  logic [DATA_W-1:0]         mem_r_data,
   output logic                      mem_w_enable,
   output logic [IDX_W-1:0]          mem_w_index,
   output logic [DATA_W-1:0]         mem_w_data,
   output logic [DATA_W-1:0]         mem_w_mask
);
   import mem1r1w_arb_pkg::*;

   localparam logic [IDX_W-1:0] RAM_LIM = IDX_W'(RAM_SIZE);

   logic [NUM_REQ-1:0] rd_gnt, wr_gnt;
   logic [IDX_W-1:0]   rd_idx, wr_idx;
   logic [DATA_W-1:0]  wr_dat, wr_msk, fwd_m;
   owner_t             rd_own;
   logic               rd_any, wr_any, rd_ok, wr_ok;
   rd_stage_t          stg_d, stg_q;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
      .clk_i   (clock),
      .rst_ni  (reset),
      .valid_i (rd_req_valid),
      .grant_o (rd_gnt)
   );

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
      .clk_i   (clock),
      .rst_ni  (reset),
      .valid_i (wr_req_valid),
      .grant_o (wr_gnt)
   );

   always_comb begin
      rd_idx = '0;
      rd_own = '0;
      wr_idx = '0;
      wr_dat = '0;
      wr_msk = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rd_gnt[i]) begin
            rd_idx = rd_req_index[i*IDX_W +: IDX_W];
            rd_own = owner_t'(i);
         end
         if (wr_gnt[i]) begin
            wr_idx = wr_req_index[i*IDX_W +: IDX_W];
            wr_dat = wr_req_data[i*DATA_W +: DATA_W];
            wr_msk = wr_req_mask[i*DATA_W +: DATA_W];
         end
      end
   end

   // Full-width compare: high index bits must not alias into the RAM.
   assign rd_any = |rd_gnt;
   assign wr_any = |wr_gnt;
   assign rd_ok  = rd_idx < RAM_LIM;
   assign wr_ok  = wr_idx < RAM_LIM;

   assign rd_req_ready = rd_gnt;
   assign wr_req_ready = wr_gnt;

   assign mem_r_enable = rd_any & rd_ok;
   assign mem_r_index  = mem_r_enable ? rd_idx : '0;

   assign mem_w_enable = wr_any & wr_ok;
   assign wr_err       = wr_any & ~wr_ok;
   assign mem_w_index  = mem_w_enable ? wr_idx : '0;
   assign mem_w_data   = mem_w_enable ? wr_dat : '0;
   assign mem_w_mask   = mem_w_enable ? wr_msk : '0;

   always_comb begin
      stg_d       = '0;
      stg_d.valid = rd_any;
      stg_d.owner = rd_own;
      stg_d.err   = rd_any & ~rd_ok;
`ifdef MEM1R1W_ARB_WR_FWD_EN
      stg_d.fwd_hit  = mem_r_enable & mem_w_enable & (rd_idx == wr_idx);
      stg_d.fwd_data = wr_dat;
      stg_d.fwd_mask = wr_msk;
`else
      stg_d.fwd_hit  = 1'b0;
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset) stg_q <= '0;
      else        stg_q <= stg_d;
   end

   // Without forwarding the fwd fields are constant zero and fold away.
   assign fwd_m = stg_q.fwd_hit ? stg_q.fwd_mask : '0;

   always_comb begin
      rd_resp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++)
         rd_resp_valid[i] = reset & stg_q.valid & (stg_q.owner == owner_t'(i));
   end

   assign rd_resp_err  = reset & stg_q.valid & stg_q.err;
   assign rd_resp_data = (reset && stg_q.valid && !stg_q.err)
                         ? merge_fwd(mem_r_data, stg_q.fwd_data, fwd_m) : '0;

endmodule

// File: tb/tb_mem1r1w_arbiter.sv
// Directed bench for mem1r1w_arbiter: helper RAM model, abstract reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_mem1r1w_arbiter;

   localparam int N  = 2;
   localparam int RS = 1024;
   localparam int W  = 64;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   rd_req_valid, rd_req_ready, rd_resp_valid;
   logic [N*W-1:0] rd_req_index;
   logic [W-1:0]   rd_resp_data;
   logic           rd_resp_err;
   logic [N-1:0]   wr_req_valid, wr_req_ready;
   logic [N*W-1:0] wr_req_index, wr_req_data, wr_req_mask;
   logic           wr_err;
   logic           mem_r_enable, mem_w_enable;
   logic [W-1:0]   mem_r_index, mem_r_data, mem_w_index, mem_w_data, mem_w_mask;

   mem1r1w_arbiter #(.NUM_REQ(N), .RAM_SIZE(RS), .IDX_W(W), .DATA_W(W)) dut (
      .clock         (clock),
      .reset         (reset),
      .rd_req_valid  (rd_req_valid),
      .rd_req_index  (rd_req_index),
      .rd_req_ready  (rd_req_ready),
      .rd_resp_valid (rd_resp_valid),
      .rd_resp_data  (rd_resp_data),
      .rd_resp_err   (rd_resp_err),
      .wr_req_valid  (wr_req_valid),
      .wr_req_index  (wr_req_index),
      .wr_req_data   (wr_req_data),
      .wr_req_mask   (wr_req_mask),
      .wr_req_ready  (wr_req_ready),
      .wr_err        (wr_err),
      .mem_r_enable  (mem_r_enable),
      .mem_r_index   (mem_r_index),
      .mem_r_data    (mem_r_data),
      .mem_w_enable  (mem_w_enable),
      .mem_w_index   (mem_w_index),
      .mem_w_data    (mem_w_data),
      .mem_w_mask    (mem_w_mask)
   );

   always #5 clock = ~clock;

   // Helper RAM: sync read returns pre-write contents on a same-cycle hit.
   logic [W-1:0] hmem [RS];
   always @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < RS; i++) hmem[i] <= '0;
         mem_r_data <= '0;
      end else begin
         if (mem_r_enable) mem_r_data <= hmem[mem_r_index[9:0]];
         if (mem_w_enable)
            hmem[mem_w_index[9:0]] <= (hmem[mem_w_index[9:0]] & ~mem_w_mask) | (mem_w_data & mem_w_mask);
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Literal expectations set by the stimulus for the current cycle.
   bit           lit_on = 0;
   logic [N-1:0] l_rrdy, l_wrdy, l_rv;
   logic [W-1:0] l_rdata;
   logic         l_rerr, l_ren, l_wen, l_werr;

   // Reference model state.
   int           m_rptr = 0, m_wptr = 0, m_pown = 0;
   bit           m_pv = 0, m_perr = 0;
   logic [W-1:0] m_pdata = '0;
   logic [W-1:0] m_mem [RS];

   always @(negedge clock) begin
      int           rg, wg, j;
      logic [W-1:0] ri, wi, wd, wm, pd;
      bit           rok, wok;
      if (!reset) begin
         chk("rst_rd_ready", rd_req_ready, '0);
         chk("rst_wr_ready", wr_req_ready, '0);
         chk("rst_resp_valid", rd_resp_valid, '0);
         chk("rst_resp_err", rd_resp_err, '0);
         chk("rst_resp_data", rd_resp_data, '0);
         chk("rst_mem_r_en", mem_r_enable, '0);
         chk("rst_mem_w_en", mem_w_enable, '0);
         chk("rst_wr_err", wr_err, '0);
         m_rptr <= 0;
         m_wptr <= 0;
         m_pv   <= 0;
         for (int i = 0; i < RS; i++) m_mem[i] <= '0;
      end else begin
         rg = -1;
         wg = -1;
         for (int k = 0; k < N; k++) begin
            j = (m_rptr + k) % N;
            if (rg < 0 && rd_req_valid[j]) rg = j;
            j = (m_wptr + k) % N;
            if (wg < 0 && wr_req_valid[j]) wg = j;
         end
         ri  = (rg >= 0) ? rd_req_index[rg*W +: W] : '0;
         wi  = (wg >= 0) ? wr_req_index[wg*W +: W] : '0;
         wd  = (wg >= 0) ? wr_req_data[wg*W +: W] : '0;
         wm  = (wg >= 0) ? wr_req_mask[wg*W +: W] : '0;
         rok = (rg >= 0) && (ri < RS);
         wok = (wg >= 0) && (wi < RS);

         chk("rd_ready", rd_req_ready, (rg >= 0) ? (64'd1 << rg) : '0);
         chk("mem_r_enable", mem_r_enable, rok);
         if (rok) chk("mem_r_index", mem_r_index, ri);
         chk("wr_ready", wr_req_ready, (wg >= 0) ? (64'd1 << wg) : '0);
         chk("mem_w_enable", mem_w_enable, wok);
         chk("wr_err", wr_err, (wg >= 0) && !wok);
         if (wok) begin
            chk("mem_w_index", mem_w_index, wi);
            chk("mem_w_data", mem_w_data, wd);
            chk("mem_w_mask", mem_w_mask, wm);
         end
         chk("resp_valid", rd_resp_valid, m_pv ? (64'd1 << m_pown) : '0);
         if (m_pv) begin
            chk("resp_err", rd_resp_err, m_perr);
            chk("resp_data", rd_resp_data, m_pdata);
         end

         pd = rok ? m_mem[ri[9:0]] : '0;
`ifdef MEM1R1W_ARB_WR_FWD_EN
         if (rok && wok && ri == wi) pd = (pd & ~wm) | (wd & wm);
`endif
         m_pv    <= (rg >= 0);
         m_pown  <= rg;
         m_perr  <= (rg >= 0) && !rok;
         m_pdata <= pd;
         if (wok) m_mem[wi[9:0]] <= (m_mem[wi[9:0]] & ~wm) | (wd & wm);
         if (rg >= 0) m_rptr <= (rg + 1) % N;
         if (wg >= 0) m_wptr <= (wg + 1) % N;
      end

      if (lit_on) begin
         chk("lit_rd_ready", rd_req_ready, l_rrdy);
         chk("lit_wr_ready", wr_req_ready, l_wrdy);
         chk("lit_resp_valid", rd_resp_valid, l_rv);
         chk("lit_mem_r_en", mem_r_enable, l_ren);
         chk("lit_mem_w_en", mem_w_enable, l_wen);
         chk("lit_wr_err", wr_err, l_werr);
         if (l_rv != '0 || !reset) begin
            chk("lit_resp_data", rd_resp_data, l_rdata);
            chk("lit_resp_err", rd_resp_err, l_rerr);
         end
      end
   end

   task automatic lit(input logic [N-1:0] rrdy, input logic [N-1:0] wrdy, input logic [N-1:0] rv,
                      input logic [W-1:0] rdata, input logic rerr, input logic ren,
                      input logic wen, input logic werr);
      lit_on  = 1;
      l_rrdy  = rrdy;
      l_wrdy  = wrdy;
      l_rv    = rv;
      l_rdata = rdata;
      l_rerr  = rerr;
      l_ren   = ren;
      l_wen   = wen;
      l_werr  = werr;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      lit_on = 0;
   endtask

   task automatic set_rd(input logic [N-1:0] v, input logic [W-1:0] i0, input logic [W-1:0] i1);
      rd_req_valid = v;
      rd_req_index = {i1, i0};
   endtask

   task automatic set_wr(input logic [N-1:0] v, input logic [W-1:0] i0, input logic [W-1:0] i1,
                         input logic [W-1:0] d, input logic [W-1:0] m);
      wr_req_valid = v;
      wr_req_index = {i1, i0};
      wr_req_data  = {d, d};
      wr_req_mask  = {m, m};
   endtask

   localparam logic [W-1:0] ONES = '1;
`ifdef MEM1R1W_ARB_WR_FWD_EN
   localparam logic [W-1:0] COLL = 64'h11FF;
`else
   localparam logic [W-1:0] COLL = 64'h1111;
`endif

   initial begin
      reset = 1'b0;
      set_rd(2'b11, 64'd0, 64'd0);
      set_wr(2'b11, 64'd0, 64'd0, 64'd0, 64'd0);
      step();
      // Reset held with everything requesting
      repeat (3) begin
         lit(2'b00, 2'b00, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         step();
      end
      reset = 1'b1;
      lit(2'b01, 2'b01, 2'b00, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0); step();
      lit(2'b10, 2'b10, 2'b01, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0); step();
      // Round-robin on the read port
      set_wr(2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
      set_rd(2'b11, 64'h10, 64'h11);
      lit(2'b01, 2'b00, 2'b10, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
      lit(2'b10, 2'b00, 2'b01, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
      lit(2'b01, 2'b00, 2'b10, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
      lit(2'b10, 2'b00, 2'b01, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
      // Write then read
      set_rd(2'b00, 64'd0, 64'd0);
      set_wr(2'b10, 64'd0, 64'd5, 64'hDEAD_BEEF, ONES);
      lit(2'b00, 2'b10, 2'b10, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0); step();
      set_wr(2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
      set_rd(2'b01, 64'd5, 64'd0);
      lit(2'b01, 2'b00, 2'b00, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
      set_rd(2'b00, 64'd0, 64'd0);
      lit(2'b00, 2'b00, 2'b01, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0); step();
      // Out-of-range reads, including one that would alias if truncated
      set_rd(2'b10, 64'd0, 64'd1024);
      lit(2'b10, 2'b00, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0); step();
      set_rd(2'b01, 64'h1_0000_0005, 64'd0);
      lit(2'b01, 2'b00, 2'b10, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0); step();
      set_rd(2'b01, 64'd1023, 64'd0);
      lit(2'b01, 2'b00, 2'b01, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0); step();
      set_rd(2'b00, 64'd0, 64'd0);
      lit(2'b00, 2'b00, 2'b01, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0); step();
      // Out-of-range writes
      set_wr(2'b01, 64'd2000, 64'd0, 64'd1, ONES);
      lit(2'b00, 2'b01, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1); step();
      set_wr(2'b10, 64'd0, 64'h1_0000_0000, 64'd1, ONES);
      lit(2'b00, 2'b10, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1); step();
      // Same-cycle collision on index 7
      set_wr(2'b01, 64'd7, 64'd0, 64'h1111, ONES);
      lit(2'b00, 2'b01, 2'b00, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0); step();
      set_wr(2'b01, 64'd7, 64'd0, 64'hFFFF, 64'h00FF);
      set_rd(2'b01, 64'd7, 64'd0);
      lit(2'b01, 2'b01, 2'b00, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0); step();
      set_wr(2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
      lit(2'b01, 2'b00, 2'b01, COLL, 1'b0, 1'b1, 1'b0, 1'b0); step();
      set_rd(2'b00, 64'd0, 64'd0);
      lit(2'b00, 2'b00, 2'b01, 64'h11FF, 1'b0, 1'b0, 1'b0, 1'b0); step();
      // Reset while a read is in flight
      set_rd(2'b01, 64'd3, 64'd0);
      lit(2'b01, 2'b00, 2'b00, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
      reset = 1'b0;
      set_rd(2'b11, 64'd3, 64'd4);
      lit(2'b00, 2'b00, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0); step();
      reset = 1'b1;
      lit(2'b01, 2'b00, 2'b00, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0); step();
      set_rd(2'b00, 64'd0, 64'd0);
      lit(2'b00, 2'b00, 2'b01, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0); step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
